// File: rtl/ycc422_decimator_if.sv
// ycc422_decimator_if: 4:4:4 input stream and 4:2:2 output stream of the decimator.
interface ycc422_decimator_if #(parameter int DW = 8);
    logic          in_valid;
    logic          in_sol;
    logic [DW-1:0] y;
    logic [DW-1:0] cb;
    logic [DW-1:0] cr;
    logic          out_valid;
    logic          out_sol;
    logic [DW-1:0] out_y;
    logic [DW-1:0] out_c;
    logic          out_cr_phase;
    logic          odd_line_err;
    modport slave (
        input  in_valid, in_sol, y, cb, cr,
        output out_valid, out_sol, out_y, out_c, out_cr_phase, odd_line_err
    );
    modport master (
        output in_valid, in_sol, y, cb, cr,
        input  out_valid, out_sol, out_y, out_c, out_cr_phase, odd_line_err
    );
endinterface

// File: rtl/ycc422_decimator.sv
// ycc422_decimator: 4:4:4 to 4:2:2 horizontal chroma decimation with pixel pairing.
// CHROMA_AVG_EN selects rounded pair averaging; otherwise chroma is co-sited (even pixel only).
module ycc422_decimator #(
    parameter int DW = 8
) (
    input  logic               clk,
    input  logic               rst,
    ycc422_decimator_if.slave  s
);
    typedef enum logic {EVEN, ODD} phase_e;

    phase_e        phase_q, phase_d;
    logic [DW-1:0] y0_q, y0_d, cb0_q, cb0_d, cr0_q, cr0_d;
    logic          sol0_q, sol0_d;
    logic          pend_q, pend_d;
    logic [DW-1:0] y1_q, y1_d, c1_q, c1_d;
    logic          valid_q, valid_d, sol_q, sol_d, ph_q, ph_d, err_q, err_d;
    logic [DW-1:0] oy_q, oy_d, oc_q, oc_d;
    logic [DW-1:0] cb_dec, cr_dec;

`ifdef CHROMA_AVG_EN
    assign cb_dec = DW'(({1'b0, cb0_q} + {1'b0, s.cb} + 1'b1) >> 1);
    assign cr_dec = DW'(({1'b0, cr0_q} + {1'b0, s.cr} + 1'b1) >> 1);
`else
    assign cb_dec = cb0_q;
    assign cr_dec = cr0_q;
`endif

    always_comb begin
        phase_d = phase_q;
        y0_d    = y0_q;
        cb0_d   = cb0_q;
        cr0_d   = cr0_q;
        sol0_d  = sol0_q;
        pend_d  = 1'b0;
        y1_d    = y1_q;
        c1_d    = c1_q;
        valid_d = 1'b0;
        sol_d   = 1'b0;
        ph_d    = ph_q;
        err_d   = err_q;
        oy_d    = oy_q;
        oc_d    = oc_q;
        if (pend_q) begin
            valid_d = 1'b1;
            oy_d    = y1_q;
            oc_d    = c1_q;
            ph_d    = 1'b1;
        end
        if (s.in_valid) begin
            if (phase_q == EVEN || s.in_sol) begin
                // sol while a pixel is stored: flush the orphan as a lone Cb beat
                if (phase_q == ODD) begin
                    valid_d = 1'b1;
                    oy_d    = y0_q;
                    oc_d    = cb0_q;
                    ph_d    = 1'b0;
                    sol_d   = sol0_q;
                    err_d   = 1'b1;
                end
                y0_d    = s.y;
                cb0_d   = s.cb;
                cr0_d   = s.cr;
                sol0_d  = s.in_sol;
                phase_d = ODD;
            end else begin
                valid_d = 1'b1;
                oy_d    = y0_q;
                oc_d    = cb_dec;
                ph_d    = 1'b0;
                sol_d   = sol0_q;
                pend_d  = 1'b1;
                y1_d    = s.y;
                c1_d    = cr_dec;
                phase_d = EVEN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            phase_q <= EVEN;
            y0_q    <= '0;
            cb0_q   <= '0;
            cr0_q   <= '0;
            sol0_q  <= 1'b0;
            pend_q  <= 1'b0;
            y1_q    <= '0;
            c1_q    <= '0;
            valid_q <= 1'b0;
            sol_q   <= 1'b0;
            ph_q    <= 1'b0;
            err_q   <= 1'b0;
            oy_q    <= '0;
            oc_q    <= '0;
        end else begin
            phase_q <= phase_d;
            y0_q    <= y0_d;
            cb0_q   <= cb0_d;
            cr0_q   <= cr0_d;
            sol0_q  <= sol0_d;
            pend_q  <= pend_d;
            y1_q    <= y1_d;
            c1_q    <= c1_d;
            valid_q <= valid_d;
            sol_q   <= sol_d;
            ph_q    <= ph_d;
            err_q   <= err_d;
            oy_q    <= oy_d;
            oc_q    <= oc_d;
        end
    end

    assign s.out_valid    = valid_q;
    assign s.out_sol      = sol_q;
    assign s.out_y        = oy_q;
    assign s.out_c        = oc_q;
    assign s.out_cr_phase = ph_q;
    assign s.odd_line_err = err_q;
endmodule

// File: tb/tb_ycc422_decimator.sv
// tb_ycc422_decimator: directed stimulus with a cycle-stamped beat scoreboard.
// Expected chroma follows CHROMA_AVG_EN the same way the build does.
module tb_ycc422_decimator;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    typedef struct {
        logic [7:0] y;
        logic [7:0] c;
        logic       ph;
        logic       sol;
        int         cyc;
    } beat_t;

    beat_t q[$];

    logic       m_odd = 1'b0;
    logic       m_err = 1'b0;
    logic [7:0] m_y0, m_cb0, m_cr0;
    logic       m_sol0;

    ycc422_decimator_if #(.DW(8)) bus ();
    ycc422_decimator #(.DW(8)) dut (.clk(clk), .rst(rst), .s(bus.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] dec(input logic [7:0] a, input logic [7:0] b);
`ifdef CHROMA_AVG_EN
        return 8'((int'(a) + int'(b) + 1) / 2);
`else
        return a;
`endif
    endfunction

    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            n_tests++;
            assert (q.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_beat: observed y=%0h c=%0h expected none", bus.out_y, bus.out_c);
            end
            if (q.size() != 0) begin
                beat_t b;
                b = q.pop_front();
                chk("beat_cycle", cyc, b.cyc);
                chk("beat_y", int'(bus.out_y), int'(b.y));
                chk("beat_c", int'(bus.out_c), int'(b.c));
                chk("beat_phase", int'(bus.out_cr_phase), int'(b.ph));
                chk("beat_sol", int'(bus.out_sol), int'(b.sol));
            end
        end
    end

    task automatic pix(input logic sol, input logic [7:0] py, input logic [7:0] pcb, input logic [7:0] pcr);
        int acc;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_sol   = sol;
        bus.y        = py;
        bus.cb       = pcb;
        bus.cr       = pcr;
        acc = cyc + 1;
        if (!m_odd || sol) begin
            if (m_odd) begin
                q.push_back('{m_y0, m_cb0, 1'b0, m_sol0, acc});
                m_err = 1'b1;
            end
            {m_y0, m_cb0, m_cr0, m_sol0} = {py, pcb, pcr, sol};
            m_odd = 1'b1;
        end else begin
            q.push_back('{m_y0, dec(m_cb0, pcb), 1'b0, m_sol0, acc});
            q.push_back('{py, dec(m_cr0, pcr), 1'b1, 1'b0, acc + 1});
            m_odd = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.in_sol   = 1'b0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        chk("drain_queue_empty", q.size(), 0);
    endtask

    initial begin
        bus.in_valid = 1'b1;
        bus.in_sol   = 1'b1;
        bus.y        = 8'h55;
        bus.cb       = 8'h66;
        bus.cr       = 8'h77;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", int'(bus.out_valid), 0);
        chk("reset_out_y", int'(bus.out_y), 0);
        chk("reset_out_c", int'(bus.out_c), 0);
        chk("reset_out_sol", int'(bus.out_sol), 0);
        chk("reset_phase", int'(bus.out_cr_phase), 0);
        chk("reset_err", int'(bus.odd_line_err), 0);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        // contiguous pair; also proves first pixel after reset is EVEN
        pix(1'b1, 8'h10, 8'h80, 8'h90);
        pix(1'b0, 8'h20, 8'h81, 8'hA0);
        idle(3);
        drain();
        // saturation and round-up corners
        pix(1'b1, 8'h01, 8'hFF, 8'hFF);
        pix(1'b0, 8'h02, 8'hFF, 8'hFF);
        pix(1'b0, 8'h03, 8'h00, 8'h00);
        pix(1'b0, 8'h04, 8'h01, 8'h01);
        idle(3);
        drain();
        // bubbles between the pair
        pix(1'b1, 8'h10, 8'h80, 8'h90);
        idle(5);
        pix(1'b0, 8'h20, 8'h81, 8'hA0);
        idle(3);
        drain();
        chk("err_clean_lines", int'(bus.odd_line_err), 0);
        // odd-length line, then new sol flushes the orphan
        pix(1'b1, 8'h31, 8'h40, 8'h60);
        pix(1'b0, 8'h32, 8'h42, 8'h63);
        pix(1'b0, 8'h33, 8'h50, 8'h70);
        pix(1'b1, 8'h40, 8'h11, 8'h22);
        pix(1'b0, 8'h41, 8'h13, 8'h24);
        idle(3);
        drain();
        chk("odd_line_err_set", int'(bus.odd_line_err), int'(m_err));
        idle(4);
        chk("odd_line_err_sticky", int'(bus.odd_line_err), 1);
        // reset mid-pair discards the stored even pixel
        pix(1'b1, 8'h77, 8'hAA, 8'hBB);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        m_odd = 1'b0;
        m_err = 1'b0;
        chk("reset_clears_err", int'(bus.odd_line_err), 0);
        chk("reset_mid_no_beat", int'(bus.out_valid), 0);
        pix(1'b0, 8'h50, 8'h80, 8'h90);
        pix(1'b0, 8'h51, 8'h81, 8'h92);
        idle(3);
        drain();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ycc422_decimator.md
Name: ycc422_decimator

Overview:
- Sits directly downstream of rgbmatrix and consumes its 4:4:4 y/cb/cr pixel stream.
- Produces a 4:2:2 stream: one luma and one alternating chroma sample per output beat (Cb on even beats, Cr on odd beats).
- Chroma is horizontally decimated per pixel pair using rounded averaging.
- Feeds the downstream line packer/output interface; throughput is up to 1 pixel/clk.

Parameters:
- DW, 8, bit width of every y/cb/cr sample on input and output.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-low reset. Asserted (0) clears all state on the next rising clk edge.
- in_valid  input  1  input pixel qualifier.
- in_sol  input  1  start of line; valid only with in_valid.
- y  input  DW  luma from rgbmatrix.
- cb  input  DW  Cb from rgbmatrix.
- cr  input  DW  Cr from rgbmatrix.
- out_valid  output  1  output beat qualifier.
- out_sol  output  1  first beat of a line; qualified by out_valid.
- out_y  output  DW  luma of the output beat.
- out_c  output  DW  chroma of the output beat: Cb on even beats, Cr on odd beats.
- out_cr_phase  output  1  0 = out_c carries Cb, 1 = out_c carries Cr.
- odd_line_err  output  1  sticky flag: a line had an odd pixel count.

Behaviour:
- Reset (rst=0 at a clk edge): all outputs go to 0, phase=EVEN, pending-odd register is cleared, odd_line_err=0. No input is accepted during that cycle.
- Reset mid-pair discards the stored even pixel and any pending odd beat; no partial output is ever emitted.
- Input phase:
  - Tracked by a 1-bit state EVEN/ODD.
  - An accepted pixel with in_sol=1 is always treated as EVEN and restarts pairing.
  - Without in_sol, accepted pixels alternate EVEN, ODD, EVEN, ...
- Accepting an EVEN pixel at cycle t: store y0/cb0/cr0 and sol0; set phase=ODD; emit nothing at t+1.
- Accepting an ODD pixel (y1/cb1/cr1) at cycle t:
  - Cycle t+1: out_valid=1, out_y=y0, out_c=(cb0+cb1+1)>>1, out_cr_phase=0, out_sol=sol0.
  - Cycle t+2: out_valid=1, out_y=y1, out_c=(cr0+cr1+1)>>1, out_cr_phase=1, out_sol=0.
  - Phase returns to EVEN.
- Arithmetic: sums are computed at DW+1 bits, then right-shifted by 1. Overflow is impossible; 255+255+1 yields 255.
- Bubbles: in_valid=0 holds all state. The stored even pixel waits indefinitely. out_valid=0 on every cycle with no scheduled beat.
- Collisions are impossible: the odd beat at t+2 can only coincide with acceptance of an EVEN pixel, which emits nothing.
- Odd-length line (in_sol accepted while phase=ODD):
  - Cycle t+1: flush the orphan as a single beat: out_y=y0, out_c=cb0 (unaveraged), out_cr_phase=0, out_sol=sol0. Its Cr is dropped.
  - odd_line_err is set and stays 1 until reset.
  - The new in_sol pixel is stored as EVEN in the same cycle.
- Outputs are registered. out_y and out_c hold their last values when out_valid=0.

Optional Feature:
- CHROMA_AVG_EN
- Defined: rounded pair averaging, as described above.
- Undefined: co-sited decimation. Cb beat carries cb0 and Cr beat carries cr0; cb1/cr1 are ignored and the adders are removed. Latency, phase handling and flush behaviour are unchanged.

Test Plan:
- Reset: hold rst=0 for 2 clk with in_valid=1 -> all outputs 0, no out_valid; first pixel after rst=1 treated as EVEN.
- Pair averaging (CHROMA_AVG_EN), contiguous input:
  - Stimulus: sol pixel (y=10,cb=80,cr=90) then (y=20,cb=81,cr=A0).
  - Response: beat (10,81,phase0,sol1) followed by beat (20,98,phase1,sol0).
- Saturation corner:
  - Stimulus: cb=cr=FF on both pixels.
  - Response: out_c=FF on both beats.
  - Stimulus: 00 and 01 pair.
  - Response: out_c=01 (round-up).
- Bubbles:
  - Stimulus: even pixel, 5 idle cycles, odd pixel.
  - Response: no output during the gap; two beats at +1/+2 after the odd pixel, with values identical to the contiguous case.
- Odd line:
  - Stimulus: 3 pixels (cb=40,42,50), then in_sol.
  - Response: beats Cb=41, Cr=avg, then orphan beat out_c=50 with sol0=0; odd_line_err=1 and sticky.
- Reset mid-pair / feature off:
  - Reset mid-pair: rst=0 after the even pixel -> no output ever for it; next pixel pairs from EVEN.
  - CHROMA_AVG_EN undefined: pair (cb 80/81) -> Cb beat=80.
